giu_err_counter: RTL and testbench
==================================

# giu_err_counter

Error-accounting stage directly upstream of the GIU CSR/probe layer. Takes per-cycle single-bit (correctable) and double-bit (uncorrectable) ECC error pulses from the two GIU protected memories (memory 0 = RTT data, memory 1 = HTT control). Maintains saturating per-memory error counts, a shared correctable-error counter with a programmable threshold, sticky IRQ_C/IRQ_UC interrupts, and resilience fault flags. All outputs are registered and feed the CSR block and the probe interface unchanged.

## Interface
- CNT_W, 32, width of per-memory single/double error counts
- THR_W, 10, width of correctable-error threshold
- CERR_W, 16, width of shared correctable-error counter
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- sbe0, sbe1  in  1 each  single-bit error pulse from memory 0 / memory 1 (one error per asserted cycle)
- dbe0, dbe1  in  1 each  double-bit error pulse from memory 0 / memory 1
- selftest_fail  in  1  checker self-test failure pulse
- cerr_threshold  in  THR_W  CSR threshold, quasi-static
- irq_c_en, irq_uc_en  in  1 each  interrupt enables
- irq_c_clr, irq_uc_clr  in  1 each  write-1-to-clear pulses for IRQ_C / IRQ_UC
- cerr_clr  in  1  clears cerr_counter and cerr_over_thres_fault
- cnt_clr  in  1  clears all four per-memory counts
- single_bit_count0/1  out  CNT_W each  saturating SBE count per memory
- double_bit_count0/1  out  CNT_W each  saturating DBE count per memory
- cerr_counter  out  CERR_W  shared saturating correctable-error count
- cerr_over_thres_fault  out  1  sticky threshold-exceeded flag
- IRQ_C, IRQ_UC  out  1 each  sticky interrupts
- fault_mission_fault, fault_latent_fault  out  1 each  sticky resilience faults

## Operation
- Reset: every output is 0.
- Per-memory counts: each asserted sbeN/dbeN adds 1 to its count. Saturates at 2^CNT_W−1 with no wrap. cnt_clr forces 0 and wins over a same-cycle increment.
- cerr_counter: next = cerr_counter + sbe0 + sbe1 (0, 1 or 2). Computed CERR_W+1 bits wide and clamped to 2^CERR_W−1. cerr_clr forces 0 and drops the same-cycle increment. Not affected by cnt_clr.
- cerr_over_thres_fault: next = !cerr_clr && (fault | (cerr_next > zero-extended cerr_threshold)).
  - The comparison uses the updated counter value.
  - Threshold 0: the first SBE sets the fault.
  - Lowering the threshold below the current count sets the fault on the next clock.
  - Raising the threshold never clears the fault.
- IRQ_C: set when irq_c_en && (sbe0|sbe1). Cleared by irq_c_clr. Set wins over a same-cycle clear. Deasserting irq_c_en does not clear a pending IRQ_C.
- IRQ_UC: same rules, using irq_uc_en, dbe0|dbe1 and irq_uc_clr.
- fault_mission_fault: set by any dbe, or by cerr_over_thres_fault's next value being 1. Independent of IRQ enables. Cleared only by reset.
- fault_latent_fault: set by selftest_fail. Cleared only by reset.
- Simultaneous sbe and dbe on the same memory: both counts increment.

## Timing
- All state is flops on the rising edge of clk with asynchronous reset. No combinational input-to-output path.
- Latency: an input pulse in cycle N is visible on every affected output in cycle N+1.
- Threshold fault and mission fault assert in the same cycle the counter value crossing the threshold becomes visible.
- Reset asserted mid-operation: all outputs go to 0 asynchronously. The first event is counted on the first clock edge after reset deasserts.
- Clear inputs are single-cycle pulses. Holding a clear high keeps the target at 0 and suppresses increments for the whole time it is held.

## Test plan
- Reset, then sbe0 for 3 cycles and sbe1 for 2 cycles with one overlapping cycle -> single_bit_count0=3, single_bit_count1=2, cerr_counter=5. Each value updates one cycle after its pulse.
- cerr_threshold=4, six single SBE pulses -> cerr_over_thres_fault and fault_mission_fault rise in the cycle cerr_counter reads 5. Then cerr_clr -> counter=0, threshold fault=0, mission fault stays 1.
- irq_c_en=1, sbe0 and irq_c_clr in the same cycle -> IRQ_C=1. A lone irq_c_clr in the next cycle -> IRQ_C=0. With irq_uc_en=0, dbe1 -> IRQ_UC=0, double_bit_count1=1, fault_mission_fault=1.
- Preload cerr_counter to 0xFFFE via forced stimulus, then sbe0 and sbe1 together -> cerr_counter=0xFFFF. Further SBEs hold 0xFFFF. Per-memory count preloaded to 0xFFFFFFFF holds on increment.
- cnt_clr in the same cycle as dbe0 -> double_bit_count0=0 and cerr_counter unchanged. selftest_fail pulse -> fault_latent_fault=1, held until reset.
- Assert reset asynchronously between clock edges with all outputs nonzero -> all outputs 0 before the next edge.

Source files
------------

// File: rtl/giu_err_counter.sv
// ECC error accounting for the two GIU protected memories: saturating per-memory
// counts, a shared correctable-error counter with threshold, sticky IRQs and faults.
module giu_err_counter #(
    parameter int CNT_W  = 32,
    parameter int THR_W  = 10,
    parameter int CERR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sbe0,
    input  logic              sbe1,
    input  logic              dbe0,
    input  logic              dbe1,
    input  logic              selftest_fail,
    input  logic [THR_W-1:0]  cerr_threshold,
    input  logic              irq_c_en,
    input  logic              irq_uc_en,
    input  logic              irq_c_clr,
    input  logic              irq_uc_clr,
    input  logic              cerr_clr,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  single_bit_count0,
    output logic [CNT_W-1:0]  single_bit_count1,
    output logic [CNT_W-1:0]  double_bit_count0,
    output logic [CNT_W-1:0]  double_bit_count1,
    output logic [CERR_W-1:0] cerr_counter,
    output logic              cerr_over_thres_fault,
    output logic              IRQ_C,
    output logic              IRQ_UC,
    output logic              fault_mission_fault,
    output logic              fault_latent_fault
);

    localparam int CMP_W = (CERR_W > THR_W) ? CERR_W : THR_W;

    logic [CNT_W-1:0]  sbc0_q, sbc0_d, sbc1_q, sbc1_d;
    logic [CNT_W-1:0]  dbc0_q, dbc0_d, dbc1_q, dbc1_d;
    logic [CERR_W-1:0] cerr_q, cerr_d;
    logic [CERR_W:0]   cerr_sum;
    logic [CMP_W-1:0]  cerr_cmp, thr_cmp;
    logic              thr_fault_q, thr_fault_d;
    logic              irq_c_q, irq_c_d;
    logic              irq_uc_q, irq_uc_d;
    logic              mission_q, mission_d;
    logic              latent_q, latent_d;

    // Clear beats increment; the count sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] cur,
                                                  input logic inc, input logic clr);
        logic [CNT_W-1:0] nxt;
        nxt = cur;
        if (clr) begin
            nxt = '0;
        end else if (inc && (cur != {CNT_W{1'b1}})) begin
            nxt = cur + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        cnt_next = nxt;
    endfunction

    always_comb begin
        sbc0_d = cnt_next(sbc0_q, sbe0, cnt_clr);
        sbc1_d = cnt_next(sbc1_q, sbe1, cnt_clr);
        dbc0_d = cnt_next(dbc0_q, dbe0, cnt_clr);
        dbc1_d = cnt_next(dbc1_q, dbe1, cnt_clr);

        // One extra bit catches the overflow so the clamp is a single MSB test.
        cerr_sum = {1'b0, cerr_q} + {{CERR_W{1'b0}}, sbe0} + {{CERR_W{1'b0}}, sbe1};
        if (cerr_clr) begin
            cerr_d = '0;
        end else if (cerr_sum[CERR_W]) begin
            cerr_d = '1;
        end else begin
            cerr_d = cerr_sum[CERR_W-1:0];
        end

        cerr_cmp    = CMP_W'(cerr_d);
        thr_cmp     = CMP_W'(cerr_threshold);
        thr_fault_d = !cerr_clr && (thr_fault_q || (cerr_cmp > thr_cmp));

        irq_c_d   = (irq_c_en && (sbe0 || sbe1)) || (irq_c_q && !irq_c_clr);
        irq_uc_d  = (irq_uc_en && (dbe0 || dbe1)) || (irq_uc_q && !irq_uc_clr);
        mission_d = mission_q || dbe0 || dbe1 || thr_fault_d;
        latent_d  = latent_q || selftest_fail;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sbc0_q      <= '0;
            sbc1_q      <= '0;
            dbc0_q      <= '0;
            dbc1_q      <= '0;
            cerr_q      <= '0;
            thr_fault_q <= 1'b0;
            irq_c_q     <= 1'b0;
            irq_uc_q    <= 1'b0;
            mission_q   <= 1'b0;
            latent_q    <= 1'b0;
        end else begin
            sbc0_q      <= sbc0_d;
            sbc1_q      <= sbc1_d;
            dbc0_q      <= dbc0_d;
            dbc1_q      <= dbc1_d;
            cerr_q      <= cerr_d;
            thr_fault_q <= thr_fault_d;
            irq_c_q     <= irq_c_d;
            irq_uc_q    <= irq_uc_d;
            mission_q   <= mission_d;
            latent_q    <= latent_d;
        end
    end

    assign single_bit_count0     = sbc0_q;
    assign single_bit_count1     = sbc1_q;
    assign double_bit_count0     = dbc0_q;
    assign double_bit_count1     = dbc1_q;
    assign cerr_counter          = cerr_q;
    assign cerr_over_thres_fault = thr_fault_q;
    assign IRQ_C                 = irq_c_q;
    assign IRQ_UC                = irq_uc_q;
    assign fault_mission_fault   = mission_q;
    assign fault_latent_fault    = latent_q;

endmodule

// File: tb/tb_giu_err_counter.sv
// Bench for giu_err_counter: a full-width instance plus a narrow instance that
// reaches per-memory saturation quickly, both tracked by an arithmetic model.
module tb_giu_err_counter;

    logic clk;
    logic reset;
    logic sbe0, sbe1, dbe0, dbe1, selftest_fail;
    logic irq_c_en, irq_uc_en, irq_c_clr, irq_uc_clr, cerr_clr, cnt_clr;
    logic [9:0] thr_m;
    logic [2:0] thr_s;

    logic [31:0] m_sbc0, m_sbc1, m_dbc0, m_dbc1;
    logic [15:0] m_cerr;
    logic        m_thr, m_irqc, m_irquc, m_mis, m_lat;
    logic [3:0]  s_sbc0, s_sbc1, s_dbc0, s_dbc1;
    logic [4:0]  s_cerr;
    logic        s_thr, s_irqc, s_irquc, s_mis, s_lat;

    giu_err_counter u_dut (
        .clk(clk), .reset(reset), .sbe0(sbe0), .sbe1(sbe1), .dbe0(dbe0), .dbe1(dbe1),
        .selftest_fail(selftest_fail), .cerr_threshold(thr_m),
        .irq_c_en(irq_c_en), .irq_uc_en(irq_uc_en), .irq_c_clr(irq_c_clr),
        .irq_uc_clr(irq_uc_clr), .cerr_clr(cerr_clr), .cnt_clr(cnt_clr),
        .single_bit_count0(m_sbc0), .single_bit_count1(m_sbc1),
        .double_bit_count0(m_dbc0), .double_bit_count1(m_dbc1),
        .cerr_counter(m_cerr), .cerr_over_thres_fault(m_thr),
        .IRQ_C(m_irqc), .IRQ_UC(m_irquc),
        .fault_mission_fault(m_mis), .fault_latent_fault(m_lat)
    );

    giu_err_counter #(.CNT_W(4), .THR_W(3), .CERR_W(5)) u_small (
        .clk(clk), .reset(reset), .sbe0(sbe0), .sbe1(sbe1), .dbe0(dbe0), .dbe1(dbe1),
        .selftest_fail(selftest_fail), .cerr_threshold(thr_s),
        .irq_c_en(irq_c_en), .irq_uc_en(irq_uc_en), .irq_c_clr(irq_c_clr),
        .irq_uc_clr(irq_uc_clr), .cerr_clr(cerr_clr), .cnt_clr(cnt_clr),
        .single_bit_count0(s_sbc0), .single_bit_count1(s_sbc1),
        .double_bit_count0(s_dbc0), .double_bit_count1(s_dbc1),
        .cerr_counter(s_cerr), .cerr_over_thres_fault(s_thr),
        .IRQ_C(s_irqc), .IRQ_UC(s_irquc),
        .fault_mission_fault(s_mis), .fault_latent_fault(s_lat)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // ---------------- reference model (index 0 = full width, 1 = narrow) ----------------
    longint md_sb0[2], md_sb1[2], md_db0[2], md_db1[2], md_cerr[2];
    bit     md_thr[2], md_irqc[2], md_irquc[2], md_mis[2], md_lat[2];

    function automatic longint sat(input longint v, input longint mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            md_sb0[i] = 0; md_sb1[i] = 0; md_db0[i] = 0; md_db1[i] = 0; md_cerr[i] = 0;
            md_thr[i] = 0; md_irqc[i] = 0; md_irquc[i] = 0; md_mis[i] = 0; md_lat[i] = 0;
        end
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            longint cmax = (i == 0) ? 64'hFFFF_FFFF : 15;
            longint emax = (i == 0) ? 65535 : 31;
            longint thr  = (i == 0) ? longint'(thr_m) : longint'(thr_s);
            longint cnew;
            md_sb0[i] = cnt_clr ? 0 : sat(md_sb0[i] + sbe0, cmax);
            md_sb1[i] = cnt_clr ? 0 : sat(md_sb1[i] + sbe1, cmax);
            md_db0[i] = cnt_clr ? 0 : sat(md_db0[i] + dbe0, cmax);
            md_db1[i] = cnt_clr ? 0 : sat(md_db1[i] + dbe1, cmax);
            cnew       = cerr_clr ? 0 : sat(md_cerr[i] + sbe0 + sbe1, emax);
            md_cerr[i] = cnew;
            md_thr[i]  = !cerr_clr && (md_thr[i] || (cnew > thr));
            md_irqc[i]  = (irq_c_en && (sbe0 || sbe1)) || (md_irqc[i] && !irq_c_clr);
            md_irquc[i] = (irq_uc_en && (dbe0 || dbe1)) || (md_irquc[i] && !irq_uc_clr);
            md_mis[i] = md_mis[i] || dbe0 || dbe1 || md_thr[i];
            md_lat[i] = md_lat[i] || selftest_fail;
        end
    endtask

    // ---------------- scoreboard ----------------
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got=%0d want=%0d", nm, $time, act, exp);
        end
    endtask

    task automatic check_model();
        chk("m_sbc0", m_sbc0, md_sb0[0]);   chk("m_sbc1", m_sbc1, md_sb1[0]);
        chk("m_dbc0", m_dbc0, md_db0[0]);   chk("m_dbc1", m_dbc1, md_db1[0]);
        chk("m_cerr", m_cerr, md_cerr[0]);  chk("m_thr", m_thr, md_thr[0]);
        chk("m_irqc", m_irqc, md_irqc[0]);  chk("m_irquc", m_irquc, md_irquc[0]);
        chk("m_mis", m_mis, md_mis[0]);     chk("m_lat", m_lat, md_lat[0]);
        chk("s_sbc0", s_sbc0, md_sb0[1]);   chk("s_sbc1", s_sbc1, md_sb1[1]);
        chk("s_dbc0", s_dbc0, md_db0[1]);   chk("s_dbc1", s_dbc1, md_db1[1]);
        chk("s_cerr", s_cerr, md_cerr[1]);  chk("s_thr", s_thr, md_thr[1]);
        chk("s_irqc", s_irqc, md_irqc[1]);  chk("s_irquc", s_irquc, md_irquc[1]);
        chk("s_mis", s_mis, md_mis[1]);     chk("s_lat", s_lat, md_lat[1]);
    endtask

    // ---------------- driver tasks ----------------
    task automatic clear_inputs();
        sbe0 = 0; sbe1 = 0; dbe0 = 0; dbe1 = 0; selftest_fail = 0;
        irq_c_en = 0; irq_uc_en = 0; irq_c_clr = 0; irq_uc_clr = 0;
        cerr_clr = 0; cnt_clr = 0;
    endtask

    // One clock: model advances on the same edge, outputs settle by the return.
    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    // in = {sbe0,sbe1,dbe0,dbe1,cnt_clr,cerr_clr,irq_c_en,irq_c_clr,irq_uc_en,irq_uc_clr,selftest}
    // flg = {IRQ_C, IRQ_UC, mission, latent}
    typedef struct packed {
        logic [10:0] in;
        logic [31:0] sbc0;
        logic [31:0] sbc1;
        logic [31:0] dbc0;
        logic [31:0] dbc1;
        logic [15:0] cerr;
        logic [3:0]  flg;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{11'b10000000000, 32'd1, 32'd0, 32'd0, 32'd0, 16'd1, 4'b0000};
        tbl[1]  = '{11'b11000000000, 32'd2, 32'd1, 32'd0, 32'd0, 16'd3, 4'b0000};
        tbl[2]  = '{11'b10000000000, 32'd3, 32'd1, 32'd0, 32'd0, 16'd4, 4'b0000};
        tbl[3]  = '{11'b01000000000, 32'd3, 32'd2, 32'd0, 32'd0, 16'd5, 4'b0000};
        tbl[4]  = '{11'b10000011000, 32'd4, 32'd2, 32'd0, 32'd0, 16'd6, 4'b1000};
        tbl[5]  = '{11'b00000011000, 32'd4, 32'd2, 32'd0, 32'd0, 16'd6, 4'b0000};
        tbl[6]  = '{11'b00010000000, 32'd4, 32'd2, 32'd0, 32'd1, 16'd6, 4'b0010};
        tbl[7]  = '{11'b00101000000, 32'd0, 32'd0, 32'd0, 32'd0, 16'd6, 4'b0010};
        tbl[8]  = '{11'b00000000001, 32'd0, 32'd0, 32'd0, 32'd0, 16'd6, 4'b0011};
        tbl[9]  = '{11'b01000010000, 32'd0, 32'd1, 32'd0, 32'd0, 16'd7, 4'b1011};
        tbl[10] = '{11'b00000000000, 32'd0, 32'd1, 32'd0, 32'd0, 16'd7, 4'b1011};
        tbl[11] = '{11'b00100000100, 32'd0, 32'd1, 32'd1, 32'd0, 16'd7, 4'b1111};
        tbl[12] = '{11'b00100000110, 32'd0, 32'd1, 32'd2, 32'd0, 16'd7, 4'b1111};
        tbl[13] = '{11'b00000000010, 32'd0, 32'd1, 32'd2, 32'd0, 16'd7, 4'b1011};
        tbl[14] = '{11'b10000100000, 32'd1, 32'd1, 32'd2, 32'd0, 16'd0, 4'b1011};

        thr_m = 10'd1023;
        thr_s = 3'd7;
        do_reset();
        check_model();
        chk("reset_cerr", m_cerr, 0);
        chk("reset_mis", m_mis, 0);

        // Table: each row is one cycle of input and the outputs one edge later.
        for (int i = 0; i < 15; i++) begin
            {sbe0, sbe1, dbe0, dbe1, cnt_clr, cerr_clr, irq_c_en, irq_c_clr,
             irq_uc_en, irq_uc_clr, selftest_fail} = tbl[i].in;
            tick();
            chk($sformatf("tbl%0d_sbc0", i), m_sbc0, tbl[i].sbc0);
            chk($sformatf("tbl%0d_sbc1", i), m_sbc1, tbl[i].sbc1);
            chk($sformatf("tbl%0d_dbc0", i), m_dbc0, tbl[i].dbc0);
            chk($sformatf("tbl%0d_dbc1", i), m_dbc1, tbl[i].dbc1);
            chk($sformatf("tbl%0d_cerr", i), m_cerr, tbl[i].cerr);
            chk($sformatf("tbl%0d_flags", i), {m_irqc, m_irquc, m_mis, m_lat}, tbl[i].flg);
            chk($sformatf("tbl%0d_thr", i), m_thr, 0);
            check_model();
        end
        clear_inputs();

        // Threshold crossing: fault and mission rise with the counter reading 5.
        do_reset();
        thr_m = 10'd4;
        for (int k = 1; k <= 6; k++) begin
            sbe0 = 1; tick();
            chk("thr_cerr", m_cerr, k);
            chk("thr_fault", m_thr, (k >= 5));
            chk("thr_mis", m_mis, (k >= 5));
        end
        sbe0 = 0; cerr_clr = 1; tick(); cerr_clr = 0;
        chk("clr_cerr", m_cerr, 0);
        chk("clr_thr", m_thr, 0);
        chk("clr_mis_kept", m_mis, 1);
        thr_m = 10'd0; sbe1 = 1; tick(); sbe1 = 0;
        chk("thr0_fault", m_thr, 1);
        // Held clear suppresses increments every cycle.
        cerr_clr = 1; sbe0 = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_clr_cerr", m_cerr, 0);
            chk("hold_clr_thr", m_thr, 0);
        end
        cerr_clr = 0;
        thr_m = 10'd10;
        repeat (3) tick();
        sbe0 = 0;
        chk("thr10_cerr", m_cerr, 3);
        chk("thr10_fault", m_thr, 0);
        thr_m = 10'd1; tick();
        chk("thr_lowered", m_thr, 1);
        thr_m = 10'd1023; tick();
        chk("thr_raised", m_thr, 1);
        check_model();

        // Shared-counter saturation and narrow per-memory saturation.
        do_reset();
        sbe0 = 1; sbe1 = 1;
        repeat (32767) tick();
        chk("cerr_fffe", m_cerr, 16'hFFFE);
        tick();
        chk("cerr_ffff", m_cerr, 16'hFFFF);
        tick();
        chk("cerr_hold", m_cerr, 16'hFFFF);
        chk("small_sbc0_sat", s_sbc0, 15);
        chk("small_cerr_sat", s_cerr, 31);
        check_model();
        sbe0 = 0; sbe1 = 0;

        // Async reset between edges with everything nonzero.
        irq_c_en = 1; irq_uc_en = 1; sbe0 = 1; dbe0 = 1; selftest_fail = 1;
        tick();
        clear_inputs();
        chk("pre_rst_lat", m_lat, 1);
        chk("pre_rst_irquc", m_irquc, 1);
        @(negedge clk); #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_model();
        chk("arst_sbc0", m_sbc0, 0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        sbe0 = 1; tick(); sbe0 = 0;
        chk("post_rst_first", m_sbc0, 1);
        check_model();

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 2000; n++) begin
            sbe0 = ($urandom_range(0, 1) == 1);
            sbe1 = ($urandom_range(0, 1) == 1);
            dbe0 = ($urandom_range(0, 9) == 0);
            dbe1 = ($urandom_range(0, 9) == 0);
            selftest_fail = ($urandom_range(0, 199) == 0);
            irq_c_en  = ($urandom_range(0, 3) != 0);
            irq_uc_en = ($urandom_range(0, 3) != 0);
            irq_c_clr  = ($urandom_range(0, 7) == 0);
            irq_uc_clr = ($urandom_range(0, 7) == 0);
            cerr_clr = ($urandom_range(0, 29) == 0);
            cnt_clr  = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 49) == 0) begin
                thr_m = 10'($urandom_range(0, 20));
                thr_s = 3'($urandom_range(0, 7));
            end
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end
            tick();
            check_model();
        end
        clear_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
